// File: rtl/log2_prenorm_pkg.sv
// Shared definitions for the log2 prenormalisation stage and the log2 unit that consumes it.
package log2_pkg;

    // Default operand format: Q5.3
    localparam int unsigned LOG2_IW = 5;
    localparam int unsigned LOG2_FW = 3;

    // Signed characteristic width for a w-bit operand.
    function automatic int unsigned char_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } prenorm_state_e;

endpackage

// File: rtl/log2_prenorm_if.sv
// Operand/result handshake bundle for log2_prenorm.
// master: the side supplying operands and accepting results; slave: the prenorm stage.
interface log2_prenorm_if #(
    parameter int unsigned W  = log2_pkg::LOG2_IW + log2_pkg::LOG2_FW,
    parameter int unsigned CW = log2_pkg::char_width(W)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_x;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [CW-1:0] out_char;
    logic [W-1:0]         out_mant;
    logic                 out_zero;

    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_char, out_mant, out_zero
    );

    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_char, out_mant, out_zero
    );
endinterface

// File: rtl/log2_prenorm_lead_one_det.sv
// Combinational priority encoder: position of the most significant set bit of x.
// none is set when x is zero; pos is then 0.
module lead_one_det #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]         x,
    output logic [$clog2(W)-1:0] pos,
    output logic                 none
);
    localparam int unsigned PW = $clog2(W);

    // Scan upward so the highest set bit wins.
    always_comb begin
        pos  = '0;
        none = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                pos  = PW'(i);
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/log2_prenorm.sv
// Log2 prenormalisation stage: finds the leading one of an unsigned Q IW.FW operand and emits
// the signed characteristic floor(log2 x) plus the mantissa normalised to Q1.(W-1).
// Build option LOG2_PRENORM_FAST_EN: normalise in one cycle through lead_one_det instead of
// shifting one bit per cycle. Results are identical; only latency differs.
module log2_prenorm
    import log2_pkg::*;
#(
    parameter int unsigned IW = LOG2_IW,
    parameter int unsigned FW = LOG2_FW
) (
    input logic          clk,
    input logic          rst,
    log2_prenorm_if.slave bus
);
    localparam int unsigned W  = IW + FW;
    localparam int unsigned CW = char_width(W);

    localparam logic signed [CW-1:0] CharTop  = CW'(IW - 1);
    localparam logic signed [CW-1:0] CharFw   = CW'(FW);
    localparam logic signed [CW-1:0] CharZero = -CharFw;
    localparam logic signed [CW-1:0] CharOne  = CW'(1);

    prenorm_state_e       state;
    logic [W-1:0]         mant;
    logic signed [CW-1:0] chr;
    logic                 zero;
    logic                 valid;

`ifdef LOG2_PRENORM_FAST_EN
    localparam int unsigned PW = $clog2(W);

    logic [PW-1:0] lod_pos;
    logic          lod_none;
    logic [PW-1:0] shamt;

    lead_one_det #(
        .W (W)
    ) u_lod (
        .x    (bus.in_x),
        .pos  (lod_pos),
        .none (lod_none)
    );

    // Left shift that brings the leading one to bit W-1.
    always_comb begin
        shamt = PW'(W - 1) - lod_pos;
    end
`endif

    // Control FSM; all outputs come straight from registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mant  <= '0;
            chr   <= '0;
            zero  <= 1'b0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef LOG2_PRENORM_FAST_EN
                        state <= DONE;
                        valid <= 1'b1;
                        if (lod_none) begin
                            zero <= 1'b1;
                            chr  <= CharZero;
                            mant <= '0;
                        end else begin
                            chr  <= $signed({1'b0, lod_pos}) - CharFw;
                            mant <= bus.in_x << shamt;
                        end
`else
                        mant <= bus.in_x;
                        if (bus.in_x == '0) begin
                            zero  <= 1'b1;
                            chr   <= CharZero;
                            state <= DONE;
                            valid <= 1'b1;
                        end else begin
                            chr   <= CharTop;
                            state <= SHIFT;
                        end
`endif
                    end
                end
                SHIFT: begin
                    if (mant[W-1]) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        mant <= mant << 1;
                        chr  <= chr - CharOne;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        zero  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = valid;
    assign bus.out_char  = chr;
    assign bus.out_mant  = mant;
    assign bus.out_zero  = zero;
endmodule

// File: tb/tb_log2_prenorm.sv
// Directed bench for log2_prenorm (Q5.3 operands). Expected latencies follow the build
// selected by LOG2_PRENORM_FAST_EN.
module tb_log2_prenorm;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    log2_prenorm_if #(.W(8), .CW(4)) bus ();

    log2_prenorm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency of one operand: accept edge counts as 1.
    function automatic int exp_lat(input int lz, input bit is_zero);
`ifdef LOG2_PRENORM_FAST_EN
        return 1;
`else
        return is_zero ? 1 : 2 + lz;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if ({bus.out_char, bus.out_mant, bus.out_zero} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs got char=%h mant=%h zero=%b want 0/00/0",
                     bus.out_char, bus.out_mant, bus.out_zero);
        end
    endtask

    task automatic test_convert(input string name, input logic [7:0] x, input logic [3:0] ch,
                                input logic [7:0] mt, input logic zr, input int lat_want);
        int lat;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s pre_in_ready got=%b want=1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_x = x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x = 8'hAA;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != lat_want) begin
            bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, lat_want);
        end
        total++;
        if (bus.out_char !== ch || bus.out_mant !== mt || bus.out_zero !== zr) begin
            bad++;
            $display("FAIL %s result got char=%h mant=%h zero=%b want char=%h mant=%h zero=%b",
                     name, bus.out_char, bus.out_mant, bus.out_zero, ch, mt, zr);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL %s busy_in_ready got=%b want=0", name, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_zero !== 1'b0) begin
            bad++;
            $display("FAIL %s after_handshake got valid=%b in_ready=%b zero=%b want 0/1/0",
                     name, bus.out_valid, bus.in_ready, bus.out_zero);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_x = 8'h05;
        @(posedge clk);
        #1;
        // Keep offering a different operand; it must be ignored while busy.
        bus.in_x = 8'hFF;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != exp_lat(5, 1'b0)) begin
            bad++; $display("FAIL bp_latency got=%0d want=%0d", lat, exp_lat(5, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== 4'hF || bus.out_mant !== 8'hA0 ||
                bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b char=%h mant=%h in_ready=%b want 1/f/a0/0",
                         i, bus.out_valid, bus.out_char, bus.out_mant, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_no_bypass got in_ready=%b want=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release got in_ready=%b valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_abort();
        bus.in_valid = 1'b1;
        bus.in_x = 8'h01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
`ifndef LOG2_PRENORM_FAST_EN
        for (int i = 0; i < 2; i++) begin
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL abort_pre[%0d] got valid=%b want=0", i, bus.out_valid);
            end
            @(posedge clk);
            #1;
        end
`else
        repeat (2) begin
            @(posedge clk);
            #1;
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL abort_post[%0d] got valid=%b in_ready=%b want 0/1",
                         i, bus.out_valid, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b0;
        test_convert("after_abort_x10", 8'h10, 4'h1, 8'h80, 1'b0, exp_lat(3, 1'b0));
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_convert("x08", 8'h08, 4'h0, 8'h80, 1'b0, exp_lat(4, 1'b0));
        test_convert("xff", 8'hFF, 4'h4, 8'hFF, 1'b0, exp_lat(0, 1'b0));
        test_convert("x01", 8'h01, 4'hD, 8'h80, 1'b0, exp_lat(7, 1'b0));
        test_convert("x00", 8'h00, 4'hD, 8'h00, 1'b1, exp_lat(0, 1'b1));
        test_convert("x4c", 8'h4C, 4'h3, 8'h98, 1'b0, exp_lat(1, 1'b0));
        test_backpressure();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
